fetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the single-cycle datapath's decode/control stage.
- Owns the fetch PC and issues word reads to an instruction memory over a req/ack handshake that tolerates variable latency.
- Buffers returned instructions with their PC in a small FIFO and hands them to the datapath over valid/ready.
- Accepts branch/jump redirects from the datapath and flushes stale work.

---
 rtl/fetch_queue.sv | 157 +++++++++++++++
 tb/tb_fetch_queue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one-at-a-time word reads
// and buffers {pc, instruction} pairs for the decode stage. Optional counters: FETCH_STATS_EN.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
`ifdef FETCH_STATS_EN
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushed,
`endif
  output logic [1:0]  dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e        state, state_n;
  logic [31:0]   fetch_pc, fetch_pc_n;
  logic [31:0]   req_addr;
  logic          issue;
  logic          push, pop;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];

  // Both the memory side (req/ack) and the datapath side (valid/ready) transfer on a
  // rising edge where both signals are high; req and valid never drop until that edge,
  // except on reset or redirect, where a redirect overrides any transfer in that cycle.
  assign push = (state == S_WAIT) && imem_ack && !redirect;
  assign pop  = out_valid && out_ready && !redirect;

  always_comb begin
    state_n    = state;
    issue      = 1'b0;
    fetch_pc_n = fetch_pc;
    if (redirect) begin
      fetch_pc_n = {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      fetch_pc_n = fetch_pc + 32'd4;
    end
    case (state)
      S_IDLE: begin
        if (!redirect && (count < DEPTH_C)) begin
          state_n = S_WAIT;
          issue   = 1'b1;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          state_n = imem_ack ? S_IDLE : S_DROP;
        end else if (imem_ack) begin
          // The next response needs a free slot of its own, pops not counted.
          if ((count + 1'b1) < DEPTH_C) begin
            state_n = S_WAIT;
            issue   = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (imem_ack) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      if (issue) req_addr <= fetch_pc_n;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
      end
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= imem_data;
        mem_pc[wr_ptr]    <= req_addr;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign imem_req        = (state != S_IDLE);
  assign imem_addr       = (state == S_IDLE) ? fetch_pc : req_addr;
  assign out_valid       = (count != '0);
  assign out_instruction = mem_instr[rd_ptr];
  assign out_pc          = mem_pc[rd_ptr];
  assign out_pc_plus4    = mem_pc[rd_ptr] + 32'd4;
  assign dbg_state       = state;

`ifdef FETCH_STATS_EN
  logic [32:0] fetched_sum, flushed_sum;
  logic        inflight_lost;

  // A response is lost once per request: only when the redirect catches it in WAIT.
  assign inflight_lost = redirect && (state == S_WAIT);
  assign fetched_sum   = {1'b0, stat_fetched} + 33'd1;
  assign flushed_sum   = {1'b0, stat_flushed} + 33'(count) + 33'(inflight_lost);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_fetched <= '0;
      stat_flushed <= '0;
    end else begin
      if (push) stat_fetched <= fetched_sum[32] ? 32'hFFFF_FFFF : fetched_sum[31:0];
      if (redirect) stat_flushed <= flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: table-driven startup vectors, directed corner sequences and a
// randomized run checked against a sequential-PC stream model. Honours FETCH_STATS_EN.
module tb_fetch_queue;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        imem_ack, redirect, out_ready;
  logic [31:0] redirect_pc;

  logic        req0, valid0, req1, valid1;
  logic [31:0] addr0, data0, instr0, pc0, pc4_0;
  logic [31:0] addr1, data1, instr1, pc1, pc4_1;
  logic [1:0]  dbg0, dbg1;
`ifdef FETCH_STATS_EN
  logic [31:0] fetched0, flushed0, fetched1, flushed1;
`endif

  // Memory returns the word index of the address.
  assign data0 = addr0 >> 2;
  assign data1 = addr1 >> 2;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u0 (
    .clock(clock), .reset_n(reset_n),
    .imem_req(req0), .imem_addr(addr0), .imem_ack(imem_ack), .imem_data(data0),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(valid0), .out_ready(out_ready),
    .out_instruction(instr0), .out_pc(pc0), .out_pc_plus4(pc4_0),
`ifdef FETCH_STATS_EN
    .stat_fetched(fetched0), .stat_flushed(flushed0),
`endif
    .dbg_state(dbg0)
  );

  fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u1 (
    .clock(clock), .reset_n(reset_n),
    .imem_req(req1), .imem_addr(addr1), .imem_ack(imem_ack), .imem_data(data1),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(valid1), .out_ready(out_ready),
    .out_instruction(instr1), .out_pc(pc1), .out_pc_plus4(pc4_1),
`ifdef FETCH_STATS_EN
    .stat_fetched(fetched1), .stat_flushed(flushed1),
`endif
    .dbg_state(dbg1)
  );

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_q[$];
  bit          expect_empty;
  bit          prev_hold;
  logic [31:0] prev_addr;
  int          lat;
  bit          rand_ack;
  int          lat_cnt;
  int          emitted;

  typedef struct {
    logic        rdy;
    logic        e_valid;
    logic        e_req;
    logic [31:0] e_addr;
    logic        chk_pc;
    logic        chk1;
    logic [31:0] e1_pc;
  } vec_t;
  vec_t tv[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    out_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ack    = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n  = 1'b1;
    exp_pc       = 32'h0;
    expect_empty = 1'b0;
    prev_hold    = 1'b0;
    lat_cnt      = 0;
  endtask

  // Check the current outputs, drive one cycle of inputs, advance past the edge.
  task automatic cycle(input logic rdy, input logic redir, input logic [31:0] rpc);
    if (expect_empty) check("valid_after_redirect", 32'(valid0), 32'd0);
    if (prev_hold && req0) check("addr_stable", addr0, prev_addr);
    if (req0) check("addr_align", 32'(addr0[1:0]), 32'd0);
    out_ready   = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    imem_ack    = req0 && (rand_ack ? ($urandom_range(0, 2) == 0) : (lat_cnt >= lat - 1));
    if (valid0 && rdy && !redir) begin
      check("stream_pc", pc0, exp_pc);
      check("stream_instr", instr0, exp_pc >> 2);
      check("stream_pc_plus4", pc4_0, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      emitted++;
    end
    if (redir) exp_pc = {rpc[31:2], 2'b00};
    expect_empty = redir;
    prev_hold    = req0 && !imem_ack;
    prev_addr    = addr0;
    lat_cnt      = (req0 && !imem_ack) ? lat_cnt + 1 : 0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int k;
    int pushes;
    logic [31:0] e;
    lat      = 1;
    rand_ack = 1'b0;
    emitted  = 0;

    // Startup with zero-wait memory; u1 covers the PC wrap from FFFF_FFF8.
    tv[0] = '{1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 32'h0};
    tv[1] = '{1'b1, 1'b0, 1'b1, 32'd0,  1'b0, 1'b0, 32'h0};
    tv[2] = '{1'b1, 1'b1, 1'b1, 32'd4,  1'b1, 1'b1, 32'hFFFF_FFF8};
    tv[3] = '{1'b1, 1'b1, 1'b1, 32'd8,  1'b1, 1'b1, 32'hFFFF_FFFC};
    tv[4] = '{1'b1, 1'b1, 1'b1, 32'd12, 1'b1, 1'b1, 32'h0000_0000};
    tv[5] = '{1'b1, 1'b1, 1'b1, 32'd16, 1'b1, 1'b1, 32'h0000_0004};
    exp_q = {32'd0, 32'd4, 32'd8, 32'd12};

    do_reset();
    check("reset_instr", instr0, 32'd0);
    check("reset_pc", pc0, 32'd0);
    check("reset_pc_plus4", pc4_0, 32'd4);
    check("reset_addr_u1", addr1, 32'hFFFF_FFF8);
`ifdef FETCH_STATS_EN
    check("reset_fetched", fetched0, 32'd0);
    check("reset_flushed", flushed0, 32'd0);
`endif
    for (int i = 0; i < 6; i++) begin
      check("tbl_valid", 32'(valid0), 32'(tv[i].e_valid));
      check("tbl_req", 32'(req0), 32'(tv[i].e_req));
      check("tbl_addr", addr0, tv[i].e_addr);
      if (tv[i].chk_pc) begin
        e = exp_q.pop_front();
        check("tbl_pc", pc0, e);
        check("tbl_instr", instr0, e >> 2);
      end
      if (tv[i].chk1) begin
        check("wrap_pc", pc1, tv[i].e1_pc);
        check("wrap_plus4", pc4_1, tv[i].e1_pc + 32'd4);
      end
      cycle(tv[i].rdy, 1'b0, 32'd0);
    end
    check("tbl_queue_drained", 32'(exp_q.size()), 32'd0);

    // Back-pressure: exactly DEPTH pushes, then fetch resumes at PC 16.
    do_reset();
    pushes = 0;
    for (int i = 0; i < 12; i++) begin
      if (req0) pushes++;
      cycle(1'b0, 1'b0, 32'd0);
    end
    check("full_pushes", 32'(pushes), 32'd4);
    check("full_req_low", 32'(req0), 32'd0);
    check("full_head_pc", pc0, 32'd0);
`ifdef FETCH_STATS_EN
    check("full_fetched", fetched0, 32'd4);
`endif
    k = 0;
    while (!req0 && k < 10) begin
      cycle(1'b1, 1'b0, 32'd0);
      k++;
    end
    check("resume_req", 32'(req0), 32'd1);
    check("resume_addr", addr0, 32'd16);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'd0);
    check("resume_progress", exp_pc, 32'd48);

    // Three-cycle latency, redirect on the second WAIT cycle.
    do_reset();
    lat = 3;
    cycle(1'b1, 1'b0, 32'd0);
    check("lat_req", 32'(req0), 32'd1);
    cycle(1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 32'h0000_0103);
    check("drop_req", 32'(req0), 32'd1);
    check("drop_addr_held", addr0, 32'd0);
    cycle(1'b1, 1'b0, 32'd0);
    check("drop_done_req", 32'(req0), 32'd0);
    cycle(1'b1, 1'b0, 32'd0);
    check("refetch_addr", addr0, 32'h0000_0100);
    k = 0;
    while (!valid0 && k < 20) begin
      cycle(1'b1, 1'b0, 32'd0);
      k++;
    end
    check("refetch_valid", 32'(valid0), 32'd1);
    check("refetch_pc", pc0, 32'h0000_0100);
`ifdef FETCH_STATS_EN
    check("drop_flushed", flushed0, 32'd1);
`endif

    // Redirect together with ack and pop while two entries are queued.
    do_reset();
    lat = 1;
    repeat (3) cycle(1'b0, 1'b0, 32'd0);
    check("pre_redir_valid", 32'(valid0), 32'd1);
    check("pre_redir_pc", pc0, 32'd0);
    check("pre_redir_req", 32'(req0), 32'd1);
    cycle(1'b1, 1'b1, 32'h0000_0200);
    check("redir_req", 32'(req0), 32'd0);
`ifdef FETCH_STATS_EN
    check("redir_flushed", flushed0, 32'd3);
    check("redir_fetched", fetched0, 32'd2);
`endif
    k = 0;
    while (!valid0 && k < 20) begin
      cycle(1'b1, 1'b0, 32'd0);
      k++;
    end
    check("redir_first_pc", pc0, 32'h0000_0200);

    // Asynchronous reset mid-WAIT with three entries queued.
    do_reset();
    repeat (4) cycle(1'b0, 1'b0, 32'd0);
    check("mid_req", 32'(req0), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("areset_req", 32'(req0), 32'd0);
    check("areset_valid", 32'(valid0), 32'd0);
    check("areset_addr", addr0, 32'd0);
    check("areset_pc_plus4", pc4_0, 32'd4);
`ifdef FETCH_STATS_EN
    check("areset_fetched", fetched0, 32'd0);
    check("areset_flushed", flushed0, 32'd0);
`endif
    @(posedge clock);
    #1 reset_n = 1'b1;
    exp_pc = 32'h0; expect_empty = 1'b0; prev_hold = 1'b0; lat_cnt = 0;
    k = 0;
    while (!valid0 && k < 20) begin
      cycle(1'b1, 1'b0, 32'd0);
      k++;
    end
    check("restart_pc", pc0, 32'd0);

    // Random ack timing, back-pressure and redirects against the stream model.
    do_reset();
    rand_ack = 1'b1;
    emitted  = 0;
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, $urandom());
    end
    check("random_emitted_some", 32'(emitted > 50), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
